// File: rtl/mod_sub_pkg.sv
// mod_sub_pkg: shared FSM states, default limb width and index-width helper for mod_sub_serial
package mod_sub_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_CORR, ST_DONE} state_t;

   localparam int LIMB_DEF = 32;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mod_sub_serial_if.sv
// mod_sub_serial_if: request/result bundle between the caller and mod_sub_serial
interface mod_sub_serial_if #(
   parameter int WIDTH = 256
);
   logic             start;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic [WIDTH-1:0] p_i;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] r_o;
   logic             borrow_o;

   modport master (output start, a_i, b_i, p_i, input busy, done, r_o, borrow_o);
   modport slave  (input start, a_i, b_i, p_i, output busy, done, r_o, borrow_o);
endinterface

// File: rtl/mod_sub_limb.sv
// mod_sub_limb: one limb of add/subtract; subtraction is x + ~y with the caller's carry-in
module mod_sub_limb #(
   parameter int W = 32
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic         inv_i,
   input  logic         c_i,
   output logic [W-1:0] s_o,
   output logic         c_o
);

   assign {c_o, s_o} = {1'b0, x_i} + {1'b0, inv_i ? ~y_i : y_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/mod_sub_serial.sv
// mod_sub_serial: limb-serial r = (a - b) mod p; MOD_SUB_CONST_TIME_EN forces the correction pass every time
module mod_sub_serial
   import mod_sub_pkg::*;
#(
   parameter int WIDTH = 256,
   parameter int LIMB  = LIMB_DEF
) (
   input logic             clk,
   input logic             rst_n,
   mod_sub_serial_if.slave bus
);

   localparam int NLIMB = WIDTH / LIMB;
   localparam int IW    = idx_w(NLIMB);

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             c_q, c_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, r_q, r_d;
   logic [LIMB-1:0]  lx, ly, ls;
   logic             linv, lc, last;

   // The adder sees a/b in SUB and the partial result/p in CORR; p is masked by the borrow
   // so the constant-time build adds zero when no correction is needed.
   assign linv = (state_q != ST_CORR);
   assign lx   = linv ? a_q[LIMB-1:0] : r_q[LIMB-1:0];
   assign ly   = linv ? b_q[LIMB-1:0] : (borrow_q ? p_q[LIMB-1:0] : '0);
   assign last = (idx_q == IW'(NLIMB - 1));

   mod_sub_limb #(.W(LIMB)) u_limb (
      .x_i   (lx),
      .y_i   (ly),
      .inv_i (linv),
      .c_i   (c_q),
      .s_o   (ls),
      .c_o   (lc)
   );

   // Next-state: operands shift right one limb per cycle, results enter at the top of r
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      c_d      = c_q;
      borrow_d = borrow_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      a_d      = a_q;
      b_d      = b_q;
      p_d      = p_q;
      r_d      = r_q;
      case (state_q)
         ST_IDLE: if (bus.start) begin
            a_d     = bus.a_i;
            b_d     = bus.b_i;
            p_d     = bus.p_i;
            r_d     = '0;
            c_d     = 1'b1;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_SUB;
         end
         ST_SUB: begin
            r_d   = {ls, r_q[WIDTH-1:LIMB]};
            a_d   = a_q >> LIMB;
            b_d   = b_q >> LIMB;
            c_d   = lc;
            idx_d = idx_q + IW'(1);
            if (last) begin
               borrow_d = ~lc;
               c_d      = 1'b0;
               idx_d    = '0;
`ifdef MOD_SUB_CONST_TIME_EN
               state_d  = ST_CORR;
`else
               state_d  = lc ? ST_DONE : ST_CORR;
`endif
            end
         end
         ST_CORR: begin
            r_d   = {ls, r_q[WIDTH-1:LIMB]};
            p_d   = p_q >> LIMB;
            c_d   = lc;
            idx_d = idx_q + IW'(1);
            if (last) begin
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         default: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset drops any operation in flight and clears the visible result
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
      c_q <= c_d;
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         r_q      <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         r_q      <= r_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.r_o      = r_q;
   assign bus.borrow_o = borrow_q;

endmodule
